// File: rtl/bp_pkt_arb_pkg.sv
// Shared types and constants for the two-source BytePipe packet arbiter.
// Holds the owner-state encoding, the byte width and the idle-counter sizing helper.
package bpPkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_e;

   localparam int BP_DW = 8;

   function automatic int to_cnt_w(input int unsigned cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/bp_pkt_arb.sv
// Packet-atomic round-robin arbiter merging two BytePipe sources onto one downstream port.
// A stalled owner (valid low) loses its grant after TIMEOUT_CYCLES enabled idle cycles.
module bp_pkt_arb
   import bpPkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_cg,
   input  logic [BP_DW-1:0] i_src0_data,
   input  logic             i_src0_valid,
   input  logic             i_src0_last,
   output logic             o_src0_ready,
   input  logic [BP_DW-1:0] i_src1_data,
   input  logic             i_src1_valid,
   input  logic             i_src1_last,
   output logic             o_src1_ready,
   output logic [BP_DW-1:0] o_bp_data,
   output logic             o_bp_valid,
   input  logic             i_bp_ready,
   output logic [1:0]       o_grant,
   output logic [7:0]       o_timeoutCount
);

   localparam int CW = to_cnt_w(TIMEOUT_CYCLES);
   // The edge that ends the TIMEOUT_CYCLES-th idle cycle is the revoking edge.
   localparam logic [CW-1:0] IDLE_LIMIT = CW'(TIMEOUT_CYCLES - 1);

   state_e        state_q, state_d;
   logic          last_owner_q, last_owner_d;
   logic [CW-1:0] idle_cnt_q, idle_cnt_d;
   logic [7:0]    to_cnt_q, to_cnt_d;

   logic own0, own1, own_valid, own_last, xfer;

   always_comb begin
      own0      = (state_q == OWN0);
      own1      = (state_q == OWN1);
      own_valid = (own0 & i_src0_valid) | (own1 & i_src1_valid);
      own_last  = own0 ? i_src0_last : i_src1_last;
      xfer      = own_valid & i_bp_ready & i_cg;

      o_src0_ready   = own0 & i_bp_ready;
      o_src1_ready   = own1 & i_bp_ready;
      o_bp_valid     = own_valid;
      o_bp_data      = own0 ? i_src0_data : (own1 ? i_src1_data : '0);
      o_grant        = {own1, own0};
      o_timeoutCount = to_cnt_q;
   end

   always_comb begin
      // NOTE: every _d starts as its _q so no path through this block can infer a latch.
      state_d      = state_q;
      last_owner_d = last_owner_q;
      idle_cnt_d   = idle_cnt_q;
      to_cnt_d     = to_cnt_q;

      if (i_cg) begin
         case (state_q)
            IDLE: begin
               idle_cnt_d = '0;
               if (i_src0_valid && (!i_src1_valid || last_owner_q)) begin
                  state_d = OWN0;
               end else if (i_src1_valid) begin
                  state_d = OWN1;
               end
            end
            OWN0, OWN1: begin
               if (xfer) begin
                  idle_cnt_d = '0;
                  if (own_last) begin
                     state_d      = IDLE;
                     last_owner_d = own1;
                  end
               end else if (!own_valid) begin
                  if (idle_cnt_q == IDLE_LIMIT) begin
                     state_d      = IDLE;
                     last_owner_d = own1;
                     idle_cnt_d   = '0;
                     if (to_cnt_q != '1) begin
                        to_cnt_d = to_cnt_q + 8'd1;
                     end
                  end else begin
                     idle_cnt_d = idle_cnt_q + CW'(1);
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= IDLE;
         last_owner_q <= 1'b1;
         idle_cnt_q   <= '0;
         to_cnt_q     <= '0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         idle_cnt_q   <= idle_cnt_d;
         to_cnt_q     <= to_cnt_d;
      end
   end

endmodule
